move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
- Buffered move queue and sequencer between the SPI command state machine and the per-motor step generators.
- Accepts move commands (duration plus per-motor direction/increment) into a small FIFO.
- Dispatches commands back-to-back to the step-generation datapath and counts each move's duration in tick strobes.
- Drives the buffer_dtr and move_done status lines and implements halt (abort and flush).

Parameters:
- motor_count, 1, number of motor channels carried per move
- move_duration_bits, 32, width of the move duration (ticks)
- increment_bits, 32, width of each motor's per-tick increment
- buffer_depth_log2, 2, FIFO depth = 2**buffer_depth_log2 entries

Ports:
- CLK  in  1  system clock
- resetn  in  1  synchronous active-low reset
- tick  in  1  one-cycle timebase strobe; advances the running move
- halt  in  1  level; abort current move and flush the queue
- wr_valid  in  1  command write request
- wr_ready  out  1  queue can accept a command
- wr_duration  in  move_duration_bits  move length in ticks
- wr_dir  in  motor_count  per-motor direction
- wr_increment  in  motor_count*increment_bits  per-motor increments, motor 0 in the LSBs
- mv_start  out  1  one-cycle pulse when new mv_* values are loaded
- mv_active  out  1  a move is executing
- mv_dir  out  motor_count  direction of the executing move
- mv_increment  out  motor_count*increment_bits  increments of the executing move
- mv_remaining  out  move_duration_bits  ticks left in the current move
- buf_count  out  buffer_depth_log2+1  queued (not yet dispatched) entries
- buffer_dtr  out  1  queue not full (data-terminal-ready to host)
- move_done  out  1  idle with empty queue

Behaviour:
- Reset is synchronous on CLK with resetn low. All of the following clear to 0: FIFO pointers, buf_count, mv_start, mv_active, mv_dir, mv_increment, mv_remaining. move_done resets to 1. State resets to IDLE.
- States and transitions:
  - IDLE: mv_active=0.
  - RUN: mv_active=1.
  - HALTED: mv_active=0.
- Write handshake: a write is accepted on an edge where wr_valid && wr_ready.
  - wr_ready = !full && state != HALTED && !halt.
  - Writes while not ready are ignored (no overflow, no error).
- Dispatch (pop):
  - Pop occurs in IDLE when the FIFO is non-empty.
  - Pop also occurs in RUN at completion when the FIFO is non-empty.
  - At the pop edge, load mv_dir, mv_increment and mv_remaining = head duration, set mv_start=1 for exactly one cycle, and enter or stay in RUN.
- Latency: a write accepted at edge k into an empty, idle scheduler gives buf_count=1 after edge k, then a pop at edge k+1 (mv_start high in cycle k+1..k+2, buf_count back to 0).
- RUN countdown: on each tick, mv_remaining decrements. Completion is a tick while mv_remaining<=1.
  - On completion with the FIFO non-empty: pop in the same edge (gapless back-to-back).
  - On completion with the FIFO empty: go to IDLE, mv_active=0, mv_remaining=0. mv_dir and mv_increment hold their last values.
- Zero duration: a popped entry with duration 0 completes on the next cycle regardless of tick. mv_start still pulses once.
- Simultaneous accept and pop: buf_count unchanged, and both pointers advance. A write into a full FIFO in the same cycle as a pop is still refused, because wr_ready uses the pre-edge full flag.
- Pointer wrap: pointers are buffer_depth_log2 bits and wrap naturally. full and empty are derived from buf_count.
- Halt has priority over every other event. While halt=1, the next edge sets:
  - state=HALTED, FIFO flushed, buf_count=0
  - mv_active=0, mv_remaining=0
  - mv_start=0; a pending pop is suppressed
  
  The scheduler stays in HALTED while halt=1. It returns to IDLE on the first edge with halt=0.
- Status outputs:
  - buffer_dtr = (buf_count < depth) && state != HALTED.
  - move_done is registered: 1 when the next state is IDLE and the next buf_count is 0. It is 0 in HALTED.
- Reset mid-operation: reset behaves like halt plus it clears the direction and increment registers. No partial pop is allowed.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, RUN, HALTED)
  - the FIFO entry width function: move_duration_bits + motor_count*(1+increment_bits)
- One sub-module, move_fifo: synchronous FIFO with a registered count, push/pop/flush inputs, and full/empty outputs.
- The scheduler FSM, countdown and status logic stay in move_scheduler.

Test Plan:
- Single move: reset; write duration=3, dir=1, inc=0x100; tick every cycle.
  - mv_start pulses once, the cycle after the accept.
  - mv_remaining goes 3,2,1, then IDLE with move_done=1.
- Back-to-back: queue durations 2 and 4 with ticks every cycle.
  - The second mv_start coincides with the first move's completion edge, with no cycle where mv_active=0.
  - Total active cycles = 6.
- Full queue (depth 4): write 5 commands with no ticks and mv_active=1.
  - buf_count peaks at 4 while the first entry runs.
  - wr_ready and buffer_dtr drop to 0; the 5th write is ignored.
  - After the next pop, buf_count=3 and wr_ready=1.
- Simultaneous push/pop: with buf_count=2, push in the same cycle as a completion pop.
  - buf_count stays 2.
  - Entry order is preserved over 8 writes, covering pointer wrap.
- Zero duration: queue durations 0, then 5, with tick held low.
  - Two mv_start pulses occur 1 cycle apart.
  - mv_remaining=5 stays frozen.
- Halt: with 3 queued entries and mv_remaining=7, assert halt for 4 cycles.
  - Next edge: mv_active=0, buf_count=0, wr_ready=0, move_done=0.
  - After halt deasserts: IDLE, move_done=1, and no stale move is dispatched.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the move scheduler: state encoding and FIFO entry sizing.
package move_scheduler_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_RUN    = 2'd1;
    localparam logic [1:0] STATE_HALTED = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = STATE_IDLE,
        RUN    = STATE_RUN,
        HALTED = STATE_HALTED
    } state_t;

    // One queued command: duration, then per-motor increments, then per-motor directions.
    function automatic int entry_width(input int duration_bits, input int motors, input int inc_bits);
        return duration_bits + motors * (1 + inc_bits);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO holding queued move commands; head entry is readable
// combinationally so the scheduler can load it on the same edge it pops.
module move_fifo #(
    parameter int width      = 65,
    parameter int depth_log2 = 2
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [width-1:0]      wr_data,
    output logic [width-1:0]      rd_data,
    output logic [depth_log2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int depth = 1 << depth_log2;
    localparam logic [depth_log2:0] depth_count = {1'b1, {depth_log2{1'b0}}};

    logic [width-1:0]      mem [depth];
    logic [depth_log2-1:0] wr_ptr_reg;
    logic [depth_log2-1:0] rd_ptr_reg;
    logic [depth_log2:0]   count_reg;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_reg == depth_count);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally; the registered count distinguishes full from empty.
    always_ff @(posedge CLK) begin
        if (!resetn || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Buffered move queue and sequencer: accepts move commands, dispatches them
// back-to-back to the step generators, counts each move down in ticks, and
// aborts/flushes on halt.
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int motor_count        = 1,
    parameter int move_duration_bits = 32,
    parameter int increment_bits     = 32,
    parameter int buffer_depth_log2  = 2
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic                                  tick,
    input  logic                                  halt,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [move_duration_bits-1:0]         wr_duration,
    input  logic [motor_count-1:0]                wr_dir,
    input  logic [motor_count*increment_bits-1:0] wr_increment,
    output logic                                  mv_start,
    output logic                                  mv_active,
    output logic [motor_count-1:0]                mv_dir,
    output logic [motor_count*increment_bits-1:0] mv_increment,
    output logic [move_duration_bits-1:0]         mv_remaining,
    output logic [buffer_depth_log2:0]            buf_count,
    output logic                                  buffer_dtr,
    output logic                                  move_done
);

    localparam int entry_bits = entry_width(move_duration_bits, motor_count, increment_bits);
    localparam int inc_total  = motor_count * increment_bits;
    localparam logic [move_duration_bits-1:0] one_tick = {{(move_duration_bits-1){1'b0}}, 1'b1};

    state_t                               state_reg;
    logic [entry_bits-1:0]                wr_entry;
    logic [entry_bits-1:0]                head_entry;
    logic [move_duration_bits-1:0]        head_duration;
    logic [inc_total-1:0]                 head_increment;
    logic [motor_count-1:0]               head_dir;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic                                 push;
    logic                                 pop;
    logic                                 complete;
    logic [buffer_depth_log2:0]           count_next;

    assign wr_entry       = {wr_dir, wr_increment, wr_duration};
    assign head_duration  = head_entry[move_duration_bits-1:0];
    assign head_increment = head_entry[move_duration_bits +: inc_total];
    assign head_dir       = head_entry[move_duration_bits + inc_total +: motor_count];

    // Ready uses the pre-edge full flag, so a pop never frees a slot for the same edge.
    assign wr_ready   = !fifo_full && (state_reg != HALTED) && !halt;
    assign buffer_dtr = !fifo_full && (state_reg != HALTED);
    assign push       = wr_valid && wr_ready;

    // A zero-length move finishes without waiting for a tick.
    assign complete = (state_reg == RUN) &&
                      ((mv_remaining == '0) || (tick && (mv_remaining == one_tick)));
    assign pop      = !halt && !fifo_empty && ((state_reg == IDLE) || complete);

    // Queue occupancy after this edge, used for the registered move_done flag.
    always_comb begin
        count_next = buf_count;
        if (push && !pop) begin
            count_next = buf_count + 1'b1;
        end else if (!push && pop) begin
            count_next = buf_count - 1'b1;
        end
    end

    move_fifo #(
        .width      (entry_bits),
        .depth_log2 (buffer_depth_log2)
    ) u_fifo (
        .CLK     (CLK),
        .resetn  (resetn),
        .push    (push),
        .pop     (pop),
        .flush   (halt),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .count   (buf_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Scheduler FSM: halt beats everything, a pop loads the next move, otherwise count down.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            mv_start     <= 1'b0;
            mv_active    <= 1'b0;
            mv_dir       <= '0;
            mv_increment <= '0;
            mv_remaining <= '0;
            move_done    <= 1'b1;
        end else if (halt) begin
            state_reg    <= HALTED;
            mv_start     <= 1'b0;
            mv_active    <= 1'b0;
            mv_remaining <= '0;
            move_done    <= 1'b0;
        end else if (pop) begin
            state_reg    <= RUN;
            mv_start     <= 1'b1;
            mv_active    <= 1'b1;
            mv_dir       <= head_dir;
            mv_increment <= head_increment;
            mv_remaining <= head_duration;
            move_done    <= 1'b0;
        end else begin
            mv_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    move_done <= (count_next == '0);
                end
                RUN: begin
                    if (complete) begin
                        state_reg    <= IDLE;
                        mv_active    <= 1'b0;
                        mv_remaining <= '0;
                        move_done    <= (count_next == '0);
                    end else begin
                        if (tick) begin
                            mv_remaining <= mv_remaining - 1'b1;
                        end
                        move_done <= 1'b0;
                    end
                end
                HALTED: begin
                    state_reg <= IDLE;
                    mv_active <= 1'b0;
                    move_done <= (count_next == '0);
                end
                default: begin
                    state_reg    <= IDLE;
                    mv_active    <= 1'b0;
                    mv_remaining <= '0;
                    move_done    <= (count_next == '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_move_scheduler;

    localparam int MC    = 1;
    localparam int DB    = 32;
    localparam int IB    = 32;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic              CLK = 1'b0;
    logic              resetn;
    logic              tick;
    logic              halt;
    logic              wr_valid;
    logic              wr_ready;
    logic [DB-1:0]     wr_duration;
    logic [MC-1:0]     wr_dir;
    logic [MC*IB-1:0]  wr_increment;
    logic              mv_start;
    logic              mv_active;
    logic [MC-1:0]     mv_dir;
    logic [MC*IB-1:0]  mv_increment;
    logic [DB-1:0]     mv_remaining;
    logic [DL:0]       buf_count;
    logic              buffer_dtr;
    logic              move_done;

    always #5 CLK = ~CLK;

    move_scheduler #(
        .motor_count        (MC),
        .move_duration_bits (DB),
        .increment_bits     (IB),
        .buffer_depth_log2  (DL)
    ) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .tick         (tick),
        .halt         (halt),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_duration  (wr_duration),
        .wr_dir       (wr_dir),
        .wr_increment (wr_increment),
        .mv_start     (mv_start),
        .mv_active    (mv_active),
        .mv_dir       (mv_dir),
        .mv_increment (mv_increment),
        .mv_remaining (mv_remaining),
        .buf_count    (buf_count),
        .buffer_dtr   (buffer_dtr),
        .move_done    (move_done)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [DB-1:0]    dur;
        logic [MC-1:0]    dir;
        logic [MC*IB-1:0] inc;
    } entry_t;

    entry_t           mq[$];
    bit               m_active;
    bit               m_halted;
    bit               m_start;
    bit               m_done;
    logic [DB-1:0]    m_rem;
    logic [MC-1:0]    m_dir;
    logic [MC*IB-1:0] m_inc;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        entry_t e;
        bit accept;
        bit finishing;
        bit can_pop;
        if (!resetn) begin
            mq.delete();
            m_active = 1'b0; m_halted = 1'b0; m_start = 1'b0;
            m_rem = '0; m_dir = '0; m_inc = '0; m_done = 1'b1;
        end else if (halt) begin
            mq.delete();
            m_halted = 1'b1; m_active = 1'b0; m_rem = '0; m_start = 1'b0; m_done = 1'b0;
        end else begin
            accept    = wr_valid && (mq.size() < DEPTH) && !m_halted;
            finishing = m_active && ((m_rem == 0) || (tick && (m_rem <= 1)));
            can_pop   = !m_halted && (!m_active || finishing) && (mq.size() > 0);
            if (can_pop) begin
                e = mq.pop_front();
                m_active = 1'b1; m_rem = e.dur; m_dir = e.dir; m_inc = e.inc;
            end else if (finishing) begin
                m_active = 1'b0; m_rem = '0;
            end else if (m_active && tick) begin
                m_rem = m_rem - 1;
            end
            m_start = can_pop;
            if (accept) begin
                e.dur = wr_duration; e.dir = wr_dir; e.inc = wr_increment;
                mq.push_back(e);
            end
            m_halted = 1'b0;
            m_done = !m_active && (mq.size() == 0);
        end
    endtask

    // Compare every output against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("mv_start",     64'(mv_start),     64'(m_start));
            check("mv_active",    64'(mv_active),    64'(m_active));
            check("mv_dir",       64'(mv_dir),       64'(m_dir));
            check("mv_increment", 64'(mv_increment), 64'(m_inc));
            check("mv_remaining", 64'(mv_remaining), 64'(m_rem));
            check("buf_count",    64'(buf_count),    64'(mq.size()));
            check("buffer_dtr",   64'(buffer_dtr),   64'((mq.size() < DEPTH) && !m_halted));
            check("wr_ready",     64'(wr_ready),     64'((mq.size() < DEPTH) && !m_halted && !halt));
            check("move_done",    64'(move_done),    64'(m_done));
        end
    end

    // Apply one cycle of inputs, step the model at the edge, settle 1 time unit.
    task automatic drive(input bit v, input logic [DB-1:0] d, input logic [MC-1:0] dr,
                         input logic [MC*IB-1:0] inc, input bit tk, input bit h);
        wr_valid = v; wr_duration = d; wr_dir = dr; wr_increment = inc; tick = tk; halt = h;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        int act_cnt;
        int starts;
        int last_start;
        logic [DB-1:0] rd;
        resetn = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("reset_move_done", 64'(move_done), 64'd1);
        check("reset_buf_count", 64'(buf_count), 64'd0);
        check("reset_active",    64'(mv_active), 64'd0);
        resetn = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Single move: duration 3, dir 1, increment 0x100, tick every cycle
        drive(1'b1, 32'd3, 1'b1, 32'h100, 1'b1, 1'b0);
        check("single_count_after_accept", 64'(buf_count), 64'd1);
        check("single_no_start_yet",       64'(mv_start),  64'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("single_start",     64'(mv_start),     64'd1);
        check("single_rem3",      64'(mv_remaining), 64'd3);
        check("single_inc",       64'(mv_increment), 64'h100);
        check("single_dir",       64'(mv_dir),       64'd1);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("single_rem2",      64'(mv_remaining), 64'd2);
        check("single_start_off", 64'(mv_start),     64'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("single_rem1",      64'(mv_remaining), 64'd1);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("single_idle",      64'(mv_active),    64'd0);
        check("single_done",      64'(move_done),    64'd1);

        // Back-to-back: durations 2 and 4, tick every cycle
        act_cnt = 0; starts = 0; last_start = -1;
        for (int i = 0; i < 10; i++) begin
            drive(i < 2, (i == 0) ? 32'd2 : 32'd4, 1'b0, 32'(i + 16), 1'b1, 1'b0);
            if (mv_active) act_cnt++;
            if (mv_start) begin starts++; last_start = i; end
        end
        check("b2b_active_cycles", 64'(act_cnt),    64'd6);
        check("b2b_starts",        64'(starts),     64'd2);
        check("b2b_second_start",  64'(last_start), 64'd3);

        // Full queue: one running move (no ticks), then 5 writes
        drive(1'b1, 32'd1, 1'b0, 32'hA0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'd1, 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        check("full_count4",  64'(buf_count),  64'd4);
        check("full_ready0",  64'(wr_ready),   64'd0);
        check("full_dtr0",    64'(buffer_dtr), 64'd0);
        drive(1'b1, 32'd1, 1'b1, 32'hBF, 1'b0, 1'b0);
        check("full_5th_ignored", 64'(buf_count), 64'd4);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("full_after_pop_count", 64'(buf_count),    64'd3);
        check("full_after_pop_ready", 64'(wr_ready),     64'd1);
        check("full_after_pop_inc",   64'(mv_increment), 64'hB0);

        // Simultaneous push and completion pop
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("sim_count2", 64'(buf_count), 64'd2);
        drive(1'b1, 32'd1, 1'b0, 32'hC5, 1'b1, 1'b0);
        check("sim_count_held", 64'(buf_count),    64'd2);
        check("sim_order",      64'(mv_increment), 64'hB2);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("sim_last_inc", 64'(mv_increment), 64'hC5);
        check("sim_drained",  64'(move_done),    64'd1);

        // Zero duration then 5, tick low
        drive(1'b1, 32'd0, 1'b0, 32'hD0, 1'b0, 1'b0);
        drive(1'b1, 32'd5, 1'b0, 32'hD5, 1'b0, 1'b0);
        check("zero_start1", 64'(mv_start),     64'd1);
        check("zero_rem0",   64'(mv_remaining), 64'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("zero_start2", 64'(mv_start),     64'd1);
        check("zero_rem5",   64'(mv_remaining), 64'd5);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        check("zero_frozen",    64'(mv_remaining), 64'd5);
        check("zero_no_restart", 64'(mv_start),    64'd0);

        // Halt with 3 queued entries and 7 ticks left
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd7, 1'b1, 32'hE7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'd2, 1'b0, 32'hE0 + 32'(i), 1'b0, 1'b0);
        check("halt_pre_count", 64'(buf_count),    64'd3);
        check("halt_pre_rem",   64'(mv_remaining), 64'd7);
        drive(1'b1, 32'd9, 1'b0, 32'hEE, 1'b0, 1'b1);
        check("halt_active",    64'(mv_active), 64'd0);
        check("halt_count",     64'(buf_count), 64'd0);
        check("halt_ready",     64'(wr_ready),  64'd0);
        check("halt_done",      64'(move_done), 64'd0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'd9, 1'b0, 32'hEE, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("unhalt_done",   64'(move_done), 64'd1);
        check("unhalt_active", 64'(mv_active), 64'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("unhalt_no_stale_start", 64'(mv_start),  64'd0);
        check("unhalt_no_stale_count", 64'(buf_count), 64'd0);

        // Randomized traffic including occasional halt and mid-operation reset
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            rd = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 4));
            drive($urandom_range(0, 9) < 6, rd, MC'($urandom), 32'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end
        resetn = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
